// File: rtl/dmux4_dispatcher_pkg.sv
// ============================================================================
//  Module      : dmux4_dispatcher_pkg
//  Description : Shared types and helpers for dmux4_dispatcher.
//                state_t  - holding register state (EMPTY / FULL)
//                rr_next  - round-robin pointer advance, 3 wraps to 0
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

`include "dispatch_defs.vh"

package dmux4_dispatcher_pkg;

  typedef enum logic [0:0] {
    EMPTY = `DISPATCH_STATE_EMPTY,
    FULL  = `DISPATCH_STATE_FULL
  } state_t;

  localparam int c_WIDTH_DEFAULT = `DISPATCH_WIDTH_DEFAULT;

  // Two-bit add wraps naturally from 3 back to 0.
  function automatic logic [1:0] rr_next(input logic [1:0] rr);
    return rr + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dispatch_defs.vh
// ============================================================================
//  File        : dispatch_defs.vh
//  Description : Shared definitions for dmux4_dispatcher. Holds the holding
//                register state encodings and the default data word width.
//                Included once by dmux4_dispatcher_pkg.
//  Revision    : 1.0  initial release
// ============================================================================
`ifndef DISPATCH_DEFS_VH
`define DISPATCH_DEFS_VH

`define DISPATCH_STATE_EMPTY   1'b0
`define DISPATCH_STATE_FULL    1'b1
`define DISPATCH_WIDTH_DEFAULT 16

`endif

// File: rtl/dmux4_dispatcher_dmux4way.sv
// ============================================================================
//  Module      : DMux4Way
//  Description : One-input, four-output demultiplexer. i_in is routed to the
//                output selected by i_sel; the other outputs are 0.
//  Ports       : i_in   - input bit
//                i_sel  - 2-bit select (0->o_a, 1->o_b, 2->o_c, 3->o_d)
//                o_a..o_d - demultiplexed outputs
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module DMux4Way (
  input  logic       i_in,
  input  logic [1:0] i_sel,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_d
);

  assign o_a = i_in & (i_sel == 2'd0);
  assign o_b = i_in & (i_sel == 2'd1);
  assign o_c = i_in & (i_sel == 2'd2);
  assign o_d = i_in & (i_sel == 2'd3);

endmodule

`default_nettype wire

// File: rtl/dmux4_dispatcher.sv
// ============================================================================
//  Module      : dmux4_dispatcher
//  Description : Single-entry holding register that dispatches each accepted
//                word to one of four downstream channels. Channels are chosen
//                round-robin, or from in_dest when DMUX4_DISPATCHER_DEST_EN is
//                defined. Sustains one word per cycle when the target channel
//                is ready; counts delivered words (16-bit, wrapping).
//  Config macro: DMUX4_DISPATCHER_DEST_EN - adds in_dest, channel = in_dest
//  Ports       : clk       - clock, rising edge
//                reset     - synchronous active-high reset
//                in_data   - upstream word       in_valid - upstream valid
//                in_ready  - word accepted this cycle
//                in_dest   - destination channel (DEST_EN builds only)
//                out_data  - held word, shared by all channels
//                out_valid - one-hot channel valid
//                out_ready - per-channel ready
//                count     - number of words delivered
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmux4_dispatcher
  import dmux4_dispatcher_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef DMUX4_DISPATCHER_DEST_EN
  input  logic [1:0]       in_dest,
`endif
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [15:0]      count
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_ch;
  logic [1:0]       r_rr;
  logic [15:0]      r_count;

  logic             w_full;
  logic             w_transfer;
  logic             w_deliver;
  logic [1:0]       w_ch_new;

  assign w_full = (r_state == FULL);

  // Reset masks both handshakes so a held word is dropped silently and
  // nothing new is taken while reset is asserted.
  assign in_ready   = ~reset & (~w_full | out_ready[r_ch]);
  assign w_transfer = in_valid & in_ready;
  assign w_deliver  = w_full & out_ready[r_ch] & ~reset;

`ifdef DMUX4_DISPATCHER_DEST_EN
  assign w_ch_new = in_dest;
`else
  assign w_ch_new = r_rr;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY:   if (w_transfer) w_state_next = FULL;
      FULL:    if (w_deliver && !w_transfer) w_state_next = EMPTY;
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_ch    <= 2'd0;
      r_rr    <= 2'd0;
      r_count <= 16'd0;
    end else begin
      r_state <= w_state_next;
      if (w_transfer) begin
        r_data <= in_data;
        r_ch   <= w_ch_new;
      end
`ifdef DMUX4_DISPATCHER_DEST_EN
      // Destination mode: the round-robin pointer is parked at 0.
      r_rr <= 2'd0;
`else
      if (w_transfer) r_rr <= rr_next(r_rr);
`endif
      if (w_deliver) r_count <= r_count + 16'd1;
    end
  end

  // Valid is gated by reset so a word held when reset arrives is never
  // presented downstream.
  DMux4Way u_valid_dmux (
    .i_in  (w_full & ~reset),
    .i_sel (r_ch),
    .o_a   (out_valid[0]),
    .o_b   (out_valid[1]),
    .o_c   (out_valid[2]),
    .o_d   (out_valid[3])
  );

  assign out_data = r_data;
  assign count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_dmux4_dispatcher.sv
// ============================================================================
//  Module      : tb_dmux4_dispatcher
//  Description : Self-checking bench for dmux4_dispatcher. A driver applies
//                directed and random stimulus, keeps a transaction-level model
//                of the dispatcher and pushes each expected delivery into a
//                queue; a monitor pops and compares whenever the DUT delivers.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmux4_dispatcher;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [15:0]  count;
`ifdef DMUX4_DISPATCHER_DEST_EN
  logic [1:0]   in_dest;
  localparam bit DEST_MODE = 1'b1;
`else
  localparam bit DEST_MODE = 1'b0;
`endif

  dmux4_dispatcher #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef DMUX4_DISPATCHER_DEST_EN
    .in_dest   (in_dest),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  // Expected deliveries: {channel, data, count shown while delivering}
  logic [33:0] exp_q[$];

  // Transaction-level model of the dispatcher
  bit          m_full;
  int          m_rr;
  int          m_ch;
  logic [15:0] m_data;
  logic [15:0] m_count;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check and advance the model.
  task automatic cyc(input bit rst, input bit iv, input logic [15:0] d,
                     input logic [3:0] ordy, input logic [1:0] dst);
    bit         exp_ir;
    logic [3:0] exp_ov;
    bit         dlv;
    bit         xfer;
    @(negedge clk);
    reset     = rst;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
`ifdef DMUX4_DISPATCHER_DEST_EN
    in_dest   = dst;
`endif
    #1;
    exp_ir = !rst && (!m_full || ordy[m_ch]);
    exp_ov = (m_full && !rst) ? (4'b0001 << m_ch) : 4'b0000;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    chk("out_valid", {28'd0, out_valid}, {28'd0, exp_ov});
    chk("count", {16'd0, count}, {16'd0, m_count});
    if (m_full) chk("out_data", {16'd0, out_data}, {16'd0, m_data});
    dlv  = m_full && !rst && ordy[m_ch];
    xfer = iv && exp_ir;
    if (dlv) exp_q.push_back({m_ch[1:0], m_data, m_count});
    if (rst) begin
      m_full = 0; m_rr = 0; m_ch = 0; m_data = '0; m_count = '0;
    end else begin
      if (dlv) m_count = m_count + 16'd1;
      if (xfer) begin
        m_data = d;
        m_ch   = DEST_MODE ? int'(dst) : m_rr;
        m_rr   = DEST_MODE ? 0 : (m_rr + 1) % 4;
        m_full = 1;
      end else if (dlv) begin
        m_full = 0;
      end
    end
  endtask

  // Monitor: every DUT delivery is matched against the next expected one.
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (started && !reset && out_valid != 4'b0000) begin
        chk("out_valid_onehot", {31'd0, $onehot(out_valid)}, 32'd1);
        for (int k = 0; k < 4; k++) begin
          if (out_valid[k] && out_ready[k]) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_delivery: got ch %0d data %h expected none", k, out_data);
            end else begin
              e = exp_q.pop_front();
              chk("dlv_ch", k, {30'd0, e[33:32]});
              chk("dlv_data", {16'd0, out_data}, {16'd0, e[31:16]});
              chk("dlv_count", {16'd0, count}, {16'd0, e[15:0]});
            end
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] c_before;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = '0;
    out_ready = 4'b0000;
`ifdef DMUX4_DISPATCHER_DEST_EN
    in_dest   = 2'd0;
`endif
    repeat (2) @(posedge clk);
    m_full = 0; m_rr = 0; m_ch = 0; m_data = '0; m_count = '0;
    started = 1'b1;

    // Reset held with in_valid high: nothing accepted or presented
    for (int i = 0; i < 3; i++) cyc(1, 1, 16'h7777, 4'b1111, 2'd0);

    // Round-robin distribution at one word per cycle
    cyc(0, 1, 16'h0011, 4'b1111, 2'd0);
    cyc(0, 1, 16'h0022, 4'b1111, 2'd1);
    cyc(0, 1, 16'h0033, 4'b1111, 2'd2);
    cyc(0, 1, 16'h0044, 4'b1111, 2'd3);
    cyc(0, 1, 16'h0055, 4'b1111, 2'd0);
    cyc(0, 0, 16'h0000, 4'b1111, 2'd0);
    cyc(0, 0, 16'h0000, 4'b1111, 2'd0);
    chk("rr_count5", {16'd0, count}, 32'd5);

    // Backpressure: 0xBEEF parked on channel 2
    cyc(0, 1, 16'h0101, 4'b1111, 2'd1);
    cyc(0, 1, 16'hBEEF, 4'b1111, 2'd2);
    for (int i = 0; i < 3; i++) cyc(0, 1, 16'hDEAD, 4'b1011, 2'd0);
    c_before = m_count;
    cyc(0, 0, 16'h0000, 4'b0100, 2'd0);
    cyc(0, 0, 16'h0000, 4'b0000, 2'd0);
    chk("bp_count_inc", {16'd0, count}, {16'd0, c_before + 16'd1});

    // Reset while holding 0x1234: word dropped, next word to channel 0
    cyc(0, 1, 16'h1234, 4'b0000, 2'd1);
    cyc(0, 0, 16'h0000, 4'b0000, 2'd0);
    cyc(1, 1, 16'h5555, 4'b1111, 2'd2);
    cyc(0, 1, 16'h4321, 4'b0000, 2'd3);
    chk("post_reset_count", {16'd0, count}, 32'd0);
    cyc(0, 0, 16'h0000, 4'b1111, 2'd0);
    cyc(0, 0, 16'h0000, 4'b1111, 2'd0);

`ifdef DMUX4_DISPATCHER_DEST_EN
    // Destination mode: in_dest = 3
    cyc(0, 1, 16'hA5A5, 4'b0000, 2'd3);
    cyc(0, 0, 16'h0000, 4'b0000, 2'd0);
    chk("dest_out_valid", {28'd0, out_valid}, 32'h8);
    chk("dest_out_data", {16'd0, out_data}, 32'hA5A5);
    cyc(0, 0, 16'h0000, 4'b1111, 2'd0);
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
          16'($urandom), 4'($urandom), 2'($urandom));
    end

    // Count wrap: 65536 deliveries from a clean reset
    cyc(1, 0, 16'h0000, 4'b1111, 2'd0);
    for (int i = 0; i < 65536; i++) cyc(0, 1, 16'(i), 4'b1111, 2'(i));
    cyc(0, 0, 16'h0000, 4'b1111, 2'd0);
    cyc(0, 0, 16'h0000, 4'b1111, 2'd0);
    chk("count_wrap", {16'd0, count}, 32'd0);

    // Every expected delivery must have been observed
    cyc(0, 0, 16'h0000, 4'b1111, 2'd0);
    @(negedge clk);
    #4;
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
